// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: instruction-sequencing FSM, PC source/enable
// generation, datapath write strobes and opcode-driven select decode.
module multi_cycle_control (
    input  logic       CLK,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [2:0] ALUOp
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_R  = 3'b110,
        S_WB_R   = 3'b111
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic       halted_q, halted_d;
    logic       first_fetch_q, first_fetch_d;

    logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_jr, is_jal, is_halt;
    logic br_taken;

    // Opcode class decode shared by the FSM and the strobe logic
    always_comb begin
        is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI) ||
                  (opcode == OP_OR)  || (opcode == OP_AND) || (opcode == OP_ORI)  ||
                  (opcode == OP_SLL) || (opcode == OP_SLT);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
        is_j    = (opcode == OP_J);
        is_jr   = (opcode == OP_JR);
        is_jal  = (opcode == OP_JAL);
        is_halt = (opcode == OP_HALT);
        br_taken = (is_beq && zero) || (is_bne && !zero);
    end

    // State, PC source, halt and first-fetch registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IF;
            pc_src_q      <= 2'b00;
            halted_q      <= 1'b0;
            first_fetch_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_src_q      <= pc_src_d;
            halted_q      <= halted_d;
            first_fetch_q <= first_fetch_d;
        end
    end

    // Next state; PC source is reloaded only on the edge that enters IF
    always_comb begin
        state_d       = state_q;
        pc_src_d      = pc_src_q;
        halted_d      = halted_q;
        first_fetch_d = first_fetch_q;
        case (state_q)
            S_IF: begin
                if (!halted_q) begin
                    state_d       = S_ID;
                    first_fetch_d = 1'b0;
                end
            end
            S_ID: begin
                if (is_halt) begin
                    state_d  = S_IF;
                    pc_src_d = 2'b00;
                    halted_d = 1'b1;
                end else if (is_jr) begin
                    state_d  = S_IF;
                    pc_src_d = 2'b10;
                end else if (is_j || is_jal) begin
                    state_d  = S_IF;
                    pc_src_d = 2'b11;
                end else if (is_beq || is_bne) begin
                    state_d = S_EXE_BR;
                end else if (is_lw || is_sw) begin
                    state_d = S_EXE_LS;
                end else if (is_r) begin
                    state_d = S_EXE_R;
                end else begin
                    state_d  = S_IF;
                    pc_src_d = 2'b00;
                end
            end
            S_EXE_R:  state_d = S_WB_R;
            S_EXE_LS: state_d = S_MEM;
            S_EXE_BR: begin
                state_d  = S_IF;
                pc_src_d = br_taken ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                if (is_lw) begin
                    state_d = S_WB_LD;
                end else begin
                    state_d  = S_IF;
                    pc_src_d = 2'b00;
                end
            end
            S_WB_R, S_WB_LD: begin
                state_d  = S_IF;
                pc_src_d = 2'b00;
            end
            default: begin
                state_d  = S_IF;
                pc_src_d = 2'b00;
            end
        endcase
    end

    // Enables and strobes; reset gating makes them drop asynchronously
    always_comb begin
        state  = state_q;
        PCSrc  = pc_src_q;
        PCWre  = reset && (state_q == S_IF) && !halted_q && !first_fetch_q;
        IRWre  = reset && (state_q == S_IF) && !halted_q;
        RegWre = reset && ((state_q == S_WB_R) || (state_q == S_WB_LD) ||
                           ((state_q == S_ID) && is_jal));
        mRD    = reset && (state_q == S_MEM) && is_lw;
        mWR    = reset && (state_q == S_MEM) && is_sw;
    end

    // Datapath selects and ALU operation, decoded straight from the opcode
    always_comb begin
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) || is_lw || is_sw;
        ExtSel    = (opcode != OP_ORI);
        DBDataSrc = is_lw;
        WrRegDSrc = !is_jal;
        RegDst    = 2'b10;
        if (is_jal) begin
            RegDst = 2'b00;
        end else if ((opcode == OP_ADDI) || (opcode == OP_ORI) || is_lw) begin
            RegDst = 2'b01;
        end
        ALUOp = 3'b000;
        case (opcode)
            OP_SUB, OP_BEQ, OP_BNE: ALUOp = 3'b001;
            OP_SLL:                 ALUOp = 3'b010;
            OP_OR, OP_ORI:          ALUOp = 3'b011;
            OP_AND:                 ALUOp = 3'b100;
            OP_SLT:                 ALUOp = 3'b110;
            default:                ALUOp = 3'b000;
        endcase
    end

endmodule
